// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared defaults and FSM encoding for the byte-wide data RAM
package dmem_pkg;

    localparam int          DMEM_DEPTH     = 4096;
    localparam logic [31:0] DMEM_BASE_ADDR = 32'h0000_0000;
    localparam logic [7:0]  DMEM_CLR_VALUE = 8'h00;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } dmem_state_e;

endpackage

// File: rtl/dmem_byte_array.sv
// rtl/dmem_byte_array.sv - DEPTHx8 storage, two sync write ports (B wins), two async read ports
module dmem_byte_array #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_a,
    input  logic [AW-1:0] idx_a,
    input  logic [7:0]    wdata_a,
    input  logic          we_b,
    input  logic [AW-1:0] idx_b,
    input  logic [7:0]    wdata_b,
    input  logic [AW-1:0] ridx_a,
    input  logic [AW-1:0] ridx_b,
    output logic [7:0]    rdata_a,
    output logic [7:0]    rdata_b
);

    logic [7:0] mem [DEPTH];

    // Port B is applied last so it overrides port A on a shared index.
    always_ff @(posedge clk) begin
        if (we_a) mem[idx_a] <= wdata_a;
        if (we_b) mem[idx_b] <= wdata_b;
    end

    assign rdata_a = mem[ridx_a];
    assign rdata_b = mem[ridx_b];

endmodule

// File: rtl/dmem_byte_ram.sv
// rtl/dmem_byte_ram.sv - dual-port byte RAM with post-reset clear and out-of-range capture
module dmem_byte_ram
    import dmem_pkg::*;
#(
    parameter int          DEPTH     = DMEM_DEPTH,
    parameter logic [31:0] BASE_ADDR = DMEM_BASE_ADDR,
    parameter logic [7:0]  CLR_VALUE = DMEM_CLR_VALUE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        we,
    input  logic [31:0] addr_a,
    input  logic [7:0]  data_a,
    input  logic [31:0] addr_b,
    input  logic [7:0]  data_b,
    output logic [7:0]  rdata_a,
    output logic [7:0]  rdata_b,
    output logic        ready,
    output logic        err,
    output logic [31:0] err_addr
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [31:0] DEPTH32  = 32'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 2);

    dmem_state_e   state, state_next;
    logic [AW-1:0] ptr;

    logic [31:0]   offset_a, offset_b;
    logic          in_a, in_b;
    logic [AW-1:0] idx_a, idx_b;

    logic          clearing;
    logic          wr_a, wr_b;
    logic [AW-1:0] widx_a, widx_b;
    logic [7:0]    wdat_a, wdat_b;
    logic [7:0]    mem_a, mem_b;

    // Offsets wrap modulo 2^32, so addresses below BASE_ADDR land far out of range.
    assign offset_a = addr_a - BASE_ADDR;
    assign offset_b = addr_b - BASE_ADDR;
    assign in_a     = offset_a < DEPTH32;
    assign in_b     = offset_b < DEPTH32;
    assign idx_a    = offset_a[AW-1:0];
    assign idx_b    = offset_b[AW-1:0];

    always_ff @(posedge clk) begin
        if (rst) state <= ST_CLEAR;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_CLEAR: if (ptr == LAST_PTR) state_next = ST_READY;
            ST_READY: state_next = ST_READY;
            default:  state_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)                    ptr <= '0;
        else if (state == ST_CLEAR) ptr <= ptr + AW'(2);
    end

    assign clearing = (state == ST_CLEAR);
    assign ready    = (state == ST_READY);

    // Clear traffic owns both write ports until the sweep completes.
    assign wr_a   = clearing | (en & we & in_a);
    assign wr_b   = clearing | (en & we & in_b);
    assign widx_a = clearing ? ptr : idx_a;
    assign widx_b = clearing ? {ptr[AW-1:1], 1'b1} : idx_b;
    assign wdat_a = clearing ? CLR_VALUE : data_a;
    assign wdat_b = clearing ? CLR_VALUE : data_b;

    dmem_byte_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .we_a    (wr_a),
        .idx_a   (widx_a),
        .wdata_a (wdat_a),
        .we_b    (wr_b),
        .idx_b   (widx_b),
        .wdata_b (wdat_b),
        .ridx_a  (idx_a),
        .ridx_b  (idx_b),
        .rdata_a (mem_a),
        .rdata_b (mem_b)
    );

    assign rdata_a = (ready && in_a) ? mem_a : 8'h00;
    assign rdata_b = (ready && in_b) ? mem_b : 8'h00;

    // Only the first offender since reset is kept; port A is preferred.
    always_ff @(posedge clk) begin
        if (rst) begin
            err      <= 1'b0;
            err_addr <= '0;
        end else if (ready && en && (!in_a || !in_b)) begin
            err <= 1'b1;
            if (!err) err_addr <= !in_a ? addr_a : addr_b;
        end
    end

endmodule
